// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_unit_pkg
// Shared CPU-side definitions for the instruction fetch stage: data widths,
// the default reset PC, the word-alignment constant and the packed entry
// format stored in the fetch output buffer.
// No ports (package).
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

  localparam int INST_W = 32;
  localparam int PC_W   = 32;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Low PC bits of every instruction address; fetch is always word aligned.
  localparam logic [1:0] WORD_ALIGN = 2'b00;

  localparam int ENTRY_W = PC_W + INST_W;

  // One decoded-ready instruction: PC in the upper half, word in the lower.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Forces a byte address onto a word boundary.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:2], WORD_ALIGN};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Bundles the fetch stage's external buses:
//   redirect / redirect_pc          : PC change request from execute
//   imem_en / imem_addr / imem_rdata : instruction BRAM read port
//   out_valid / out_ready / out_inst / out_pc : valid/ready channel to decode
// modport master : the fetch unit side
// modport slave  : the surrounding pipeline / memory side
// ---------------------------------------------------------------------------
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;

  logic              imem_en;
  logic [PC_W-1:0]   imem_addr;
  logic [INST_W-1:0] imem_rdata;

  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] out_inst;
  logic [PC_W-1:0]   out_pc;

  modport master (
    input  redirect, redirect_pc, imem_rdata, out_ready,
    output imem_en, imem_addr, out_valid, out_inst, out_pc
  );

  modport slave (
    output redirect, redirect_pc, imem_rdata, out_ready,
    input  imem_en, imem_addr, out_valid, out_inst, out_pc
  );

endinterface

// File: rtl/fetch_unit_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Small synchronous in-order FIFO holding {pc, inst} entries between the
// instruction memory return path and decode.
// Ports:
//   clk, rst (async, active high)
//   push / wdata  : write an entry at the end of the cycle
//   pop           : drop the head entry at the end of the cycle
//   flush         : discard every entry (wins over push and pop)
//   rdata         : current head entry
//   count / empty / full : occupancy status
// Push and pop may occur together at any occupancy.
// ---------------------------------------------------------------------------
module fetch_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 3,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly because DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Status flags and the qualified push/pop strobes. A push into a full
  // buffer is only accepted when the head leaves in the same cycle, so the
  // full-and-simultaneous case still works without ever overwriting data.
  always_comb begin
    empty   = (count == '0);
    full    = (count == CNT_W'(DEPTH));
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    rdata   = mem[rd_ptr];
  end

  // Pointer and occupancy bookkeeping. Flush resets everything to the empty
  // state, dropping any entry that was being written in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage. Owns the fetch PC, issues word reads to the
// instruction BRAM, tracks reads in flight for IMEM_LATENCY cycles and
// buffers returned {pc, inst} pairs for decode. Redirects from execute
// discard everything fetched down the old path.
// Ports:
//   clk, rst (async, active high)
//   bus (fetch_unit_if.master):
//     redirect, redirect_pc      : PC change request (low two bits ignored)
//     imem_en, imem_addr         : read strobe and word address
//     imem_rdata                 : read data, IMEM_LATENCY cycles after issue
//     out_valid, out_ready       : handshake to decode
//     out_inst, out_pc           : head instruction and its byte PC
// ---------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter int              IMEM_LATENCY = 1,
  parameter int              DEPTH        = IMEM_LATENCY + 2
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  logic [PC_W-1:0]  fpc;
  logic [IMEM_LATENCY-1:0] fl_valid;
  logic [PC_W-1:0]  fl_pc [IMEM_LATENCY];

  logic [CNT_W-1:0] inflight_cnt;
  logic [CNT_W-1:0] buf_cnt;
  logic             buf_empty;
  logic             buf_full;
  logic             issue;
  logic             push;
  logic             pop;
  fetch_entry_t     wr_entry;
  fetch_entry_t     head;

  // Credit check: a read may only go out if the buffer is guaranteed to have
  // room for it when it returns, counting everything already in flight and
  // everything already buffered at the start of the cycle. A pop in the same
  // cycle earns no credit. The full test is implied by the credit check and
  // only acts as a guard. Redirect cycles never issue; reset blocks issue
  // combinationally so imem_en drops as soon as rst rises.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < IMEM_LATENCY; i++) begin
      inflight_cnt = inflight_cnt + CNT_W'(fl_valid[i]);
    end
    issue = !rst && !bus.redirect && !buf_full &&
            ((SUM_W'(inflight_cnt) + SUM_W'(buf_cnt)) < SUM_W'(DEPTH));
  end

  // Memory side of the handshake plus the buffer write/pop strobes. A
  // response landing in a redirect cycle belongs to the old path and is
  // dropped; the decode handshake in that same cycle still completes.
  always_comb begin
    bus.imem_en   = issue;
    bus.imem_addr = align_pc(fpc);
    push          = fl_valid[IMEM_LATENCY-1] && !bus.redirect;
    pop           = bus.out_valid && bus.out_ready;
    wr_entry.pc   = fl_pc[IMEM_LATENCY-1];
    wr_entry.inst = bus.imem_rdata;
  end

  // Architectural fetch PC. A redirect takes the new target (word aligned);
  // otherwise each issued read advances by one word, wrapping at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc <= RESET_PC;
    end else if (bus.redirect) begin
      fpc <= align_pc(bus.redirect_pc);
    end else if (issue) begin
      fpc <= fpc + PC_W'(4);
    end
  end

  // Valid bits of the in-flight shift register: one stage per cycle of
  // memory latency, so the tail stage lines up with imem_rdata. A redirect
  // kills every outstanding read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fl_valid <= '0;
    end else if (bus.redirect) begin
      fl_valid <= '0;
    end else begin
      fl_valid[0] <= issue;
      for (int i = 1; i < IMEM_LATENCY; i++) begin
        fl_valid[i] <= fl_valid[i-1];
      end
    end
  end

  // PC tags travelling alongside the valid bits; qualified by fl_valid so
  // they need no reset.
  always_ff @(posedge clk) begin
    fl_pc[0] <= fpc;
    for (int i = 1; i < IMEM_LATENCY; i++) begin
      fl_pc[i] <= fl_pc[i-1];
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect),
    .wdata (wr_entry),
    .rdata (head),
    .count (buf_cnt),
    .empty (buf_empty),
    .full  (buf_full)
  );

  // Decode always sees the buffer head; empty buffer means nothing valid.
  always_comb begin
    bus.out_valid = !buf_empty;
    bus.out_inst  = head.inst;
    bus.out_pc    = head.pc;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit with IMEM_LATENCY=1 and RESET_PC=0.
// The memory model answers every read with the inverted address. A
// stream-level reference model predicts the fetch address sequence and the
// ordered list of PCs decode must receive; directed scenarios then check
// cycle-level timing, followed by a randomized redirect/stall phase.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int              LAT    = 1;
  localparam logic [PC_W-1:0] RST_PC = 32'h0000_0000;

  logic clk;
  logic rst;

  int checks;
  int failures;
  int hs_count;

  logic [PC_W-1:0] exp_q [$];
  logic [PC_W-1:0] model_next;
  logic [PC_W-1:0] model_fpc;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC     (RST_PC),
    .IMEM_LATENCY (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: one-cycle read returning ~addr; garbage otherwise so
  // that a response taken at the wrong time shows up as a wrong word.
  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= ~bus.imem_addr;
    else             bus.imem_rdata <= $urandom;
  end

  // Hard stop if something hangs despite the bounded waits.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time exhausted");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives the inputs for the next cycle just after its rising edge.
  task automatic applyStimulus(input logic rd, input logic [PC_W-1:0] rpc,
                               input logic rdy);
    @(posedge clk);
    #1;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.out_ready   = rdy;
  endtask

  // Reference stream: decode must see consecutive words starting at target.
  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back(model_next);
      model_next = model_next + 32'd4;
    end
  endtask

  task automatic rebuild(input logic [PC_W-1:0] target);
    exp_q.delete();
    model_next = target;
    refill();
  endtask

  // Monitor/scoreboard, sampling mid-cycle. Order inside a cycle matters: a
  // handshake in a redirect cycle consumes from the old stream before the
  // redirect restarts the stream at the new target.
  always @(negedge clk) begin
    if (rst) begin
      model_fpc = RST_PC;
      rebuild(RST_PC);
    end else begin
      if (bus.redirect) checkOutput("no_issue_on_redirect", 32'(bus.imem_en), 32'd0);
      if (bus.imem_en) begin
        checkOutput("imem_addr_seq", bus.imem_addr, model_fpc);
        model_fpc = model_fpc + 32'd4;
      end
      if (bus.out_valid && bus.out_ready) begin
        hs_count++;
        checkOutput("sb_pc", bus.out_pc, exp_q[0]);
        checkOutput("sb_inst", bus.out_inst, ~exp_q[0]);
        void'(exp_q.pop_front());
        refill();
      end
      if (bus.redirect) begin
        model_fpc = bus.redirect_pc & ~32'd3;
        rebuild(bus.redirect_pc & ~32'd3);
      end
    end
  end

  // Raises reset for one sampled cycle, checks the reset outputs, then drops
  // it; returns just after release (start of cycle c0).
  task automatic resetDut(input logic rdy);
    @(posedge clk);
    #1;
    rst             = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready   = rdy;
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_imem_en", 32'(bus.imem_en), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Runs cycles with out_ready=1 until out_valid is seen (bounded).
  task automatic waitValid(input string name, input logic [PC_W-1:0] exp_pc);
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(1'b0, '0, 1'b1);
      @(negedge clk);
      if (bus.out_valid) found = 1;
    end
    if (found) checkOutput(name, bus.out_pc, exp_pc);
    else       checkOutput({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int issues;
    logic rd;
    logic rdy;
    logic [PC_W-1:0] rpc;

    checks          = 0;
    failures        = 0;
    hs_count        = 0;
    rst             = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready   = 1'b1;
    bus.imem_rdata  = '0;
    #1;
    rst = 1'b1;

    // Scenario 1: free-running stream after reset.
    resetDut(1'b1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) applyStimulus(1'b0, '0, 1'b1);
      @(negedge clk);
      checkOutput("s1_imem_en", 32'(bus.imem_en), 32'd1);
      checkOutput("s1_imem_addr", bus.imem_addr, 32'(4 * k));
      if (k < 2) begin
        checkOutput("s1_no_valid_yet", 32'(bus.out_valid), 32'd0);
      end else begin
        checkOutput("s1_out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("s1_out_pc", bus.out_pc, 32'(4 * (k - 2)));
        checkOutput("s1_out_inst", bus.out_inst, ~32'(4 * (k - 2)));
      end
    end

    // Scenario 2: decode stalled from reset, then released.
    resetDut(1'b0);
    issues = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) applyStimulus(1'b0, '0, 1'b0);
      @(negedge clk);
      if (bus.imem_en) issues++;
    end
    checkOutput("s2_issue_count", 32'(issues), 32'd3);
    checkOutput("s2_imem_en_stalled", 32'(bus.imem_en), 32'd0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, '0, 1'b1);
      @(negedge clk);
      checkOutput("s2_out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("s2_out_pc", bus.out_pc, 32'(4 * k));
    end

    // Scenario 3: redirect into a running stream.
    resetDut(1'b1);
    for (int k = 1; k < 6; k++) applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b1, 32'h100, 1'b1);
    @(negedge clk);
    checkOutput("s3_no_issue", 32'(bus.imem_en), 32'd0);
    applyStimulus(1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("s3_issue_en", 32'(bus.imem_en), 32'd1);
    checkOutput("s3_issue_addr", bus.imem_addr, 32'h100);
    checkOutput("s3_flushed_1", 32'(bus.out_valid), 32'd0);
    applyStimulus(1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("s3_flushed_2", 32'(bus.out_valid), 32'd0);
    applyStimulus(1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("s3_valid_100", 32'(bus.out_valid), 32'd1);
    checkOutput("s3_pc_100", bus.out_pc, 32'h100);
    applyStimulus(1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("s3_pc_104", bus.out_pc, 32'h104);

    // Scenario 4: redirect coinciding with a handshake, then back-to-back.
    resetDut(1'b1);
    for (int k = 1; k < 10; k++) applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b1, 32'h103, 1'b1);
    @(negedge clk);
    checkOutput("s4_hs_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("s4_hs_pc", bus.out_pc, 32'h20);
    waitValid("s4_first_after", 32'h100);
    applyStimulus(1'b1, 32'h200, 1'b1);
    applyStimulus(1'b1, 32'h300, 1'b1);
    waitValid("s4_last_redirect_wins", 32'h300);

    // Scenario 5: PC wrap at the top of the address space.
    applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b1);
    waitValid("s5_pc_fff8", 32'hFFFF_FFF8);
    applyStimulus(1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("s5_pc_fffc", bus.out_pc, 32'hFFFF_FFFC);
    applyStimulus(1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("s5_wrap_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("s5_pc_wrap", bus.out_pc, 32'h0);
    checkOutput("s5_inst_wrap", bus.out_inst, 32'hFFFF_FFFF);

    // Scenario 6: asynchronous reset between edges, mid-stream.
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, '0, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("s6_async_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("s6_async_imem_en", 32'(bus.imem_en), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) applyStimulus(1'b0, '0, 1'b1);
      @(negedge clk);
      if (k < 2) begin
        checkOutput("s6_no_stale", 32'(bus.out_valid), 32'd0);
      end else begin
        checkOutput("s6_restart_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("s6_restart_pc", bus.out_pc, 32'(4 * (k - 2)));
      end
    end

    // Randomized phase: stalls and redirects, checked by the scoreboard.
    hs_count = 0;
    for (int n = 0; n < 3000; n++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else                           rpc = $urandom;
      applyStimulus(rd, rpc, rdy);
    end
    applyStimulus(1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("rand_progress", 32'(hs_count > 1000), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
